clk_freq_mon: RTL and testbench

CLK_FREQ_MON -- requirements
Module: clk_freq_mon

---
 rtl/clk_freq_mon.sv | 144 ++++++++++++++
 tb/tb_clk_freq_mon.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_mon.sv
// Clock frequency monitor: counts synchronised toggles of mon_tgl_i over a window of bus_clk cycles
// and flags stuck/slow/fast results. Define CLKMON_IRQ_EN to add the registered irq_o output.
module clk_freq_mon (
  input  logic        bus_clk,
  input  logic        rst_sys_n,
  input  logic        en_i,
  input  logic [15:0] win_len_i,
  input  logic [15:0] exp_min_i,
  input  logic [15:0] exp_max_i,
  input  logic        mon_tgl_i,
  input  logic        clr_i,
  output logic [15:0] cnt_o,
  output logic        done_o,
  output logic        stuck_o,
  output logic        too_slow_o,
  output logic        too_fast_o,
  output logic        busy_o
`ifdef CLKMON_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic [15:0] r_remain;
  logic [15:0] r_count;
  logic [15:0] r_min;
  logic [15:0] r_max;

  logic        w_edge;
  logic        w_report;
  logic        w_set_stuck;
  logic        w_set_slow;
  logic        w_set_fast;
  logic [15:0] w_len_eff;

  // Both toggle polarities count: any difference between stage 2 and the delay flop is one edge.
  assign w_edge      = r_sync2 ^ r_sync3;
  assign w_report    = (r_state == REPORT);
  assign w_set_stuck = w_report && (r_count == 16'd0);
  assign w_set_slow  = w_report && (r_count < r_min);
  assign w_set_fast  = w_report && (r_count > r_max);
  assign w_len_eff   = (win_len_i == 16'd0) ? 16'd1 : win_len_i;

  always_ff @(posedge bus_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= mon_tgl_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge bus_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state    <= IDLE;
      r_remain   <= 16'd0;
      r_count    <= 16'd0;
      r_min      <= 16'd0;
      r_max      <= 16'd0;
      cnt_o      <= 16'd0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
      stuck_o    <= 1'b0;
      too_slow_o <= 1'b0;
      too_fast_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en_i) begin
            r_state  <= MEASURE;
            busy_o   <= 1'b1;
            r_remain <= w_len_eff;
            r_min    <= exp_min_i;
            r_max    <= exp_max_i;
            r_count  <= 16'd0;
          end
        end
        MEASURE: begin
          if (!en_i) begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end else begin
            if (w_edge && (r_count != 16'hFFFF)) begin
              r_count <= r_count + 16'd1;
            end
            if (r_remain == 16'd1) begin
              r_state <= REPORT;
            end else begin
              r_remain <= r_remain - 16'd1;
            end
          end
        end
        REPORT: begin
          cnt_o  <= r_count;
          done_o <= 1'b1;
          if (en_i) begin
            // An edge arriving in the report cycle belongs to the next window.
            r_state  <= MEASURE;
            r_remain <= w_len_eff;
            r_min    <= exp_min_i;
            r_max    <= exp_max_i;
            r_count  <= {15'd0, w_edge};
          end else begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
      // A flag being set in the report cycle beats a simultaneous clear.
      stuck_o    <= (stuck_o    & ~clr_i) | w_set_stuck;
      too_slow_o <= (too_slow_o & ~clr_i) | w_set_slow;
      too_fast_o <= (too_fast_o & ~clr_i) | w_set_fast;
    end
  end

`ifdef CLKMON_IRQ_EN
  always_ff @(posedge bus_clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= stuck_o | too_slow_o | too_fast_o;
    end
  end
`endif

endmodule

// File: tb/tb_clk_freq_mon.sv
// Bench for clk_freq_mon: directed scenarios plus randomized toggle traffic, checked against an
// arrival-log model of which toggles land inside each measurement window.
module tb_clk_freq_mon;

  logic        bus_clk = 1'b0;
  logic        rst_sys_n;
  logic        en_i;
  logic [15:0] win_len_i;
  logic [15:0] exp_min_i;
  logic [15:0] exp_max_i;
  logic        mon_tgl_i;
  logic        clr_i;
  logic [15:0] cnt_o;
  logic        done_o;
  logic        stuck_o;
  logic        too_slow_o;
  logic        too_fast_o;
  logic        busy_o;
`ifdef CLKMON_IRQ_EN
  logic        irq_o;
  bit          prev_or;
`endif

  clk_freq_mon dut (
    .bus_clk    (bus_clk),
    .rst_sys_n  (rst_sys_n),
    .en_i       (en_i),
    .win_len_i  (win_len_i),
    .exp_min_i  (exp_min_i),
    .exp_max_i  (exp_max_i),
    .mon_tgl_i  (mon_tgl_i),
    .clr_i      (clr_i),
    .cnt_o      (cnt_o),
    .done_o     (done_o),
    .stuck_o    (stuck_o),
    .too_slow_o (too_slow_o),
    .too_fast_o (too_fast_o),
    .busy_o     (busy_o)
`ifdef CLKMON_IRQ_EN
    ,
    .irq_o      (irq_o)
`endif
  );

  // Clock / reset block
  always #5 bus_clk = ~bus_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int tgl_per = 0;
  int tgl_pct = 0;
  int tctr    = 0;

  // arr[k] = 1 when a toggle is due to be counted by the posedge with index k (3 edges after the change).
  bit arr [0:99999];

  // Scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  bit e_stuck = 1'b0;
  bit e_slow  = 1'b0;
  bit e_fast  = 1'b0;

  // cyc is the index of the next posedge; toggles are driven here and logged with their arrival index.
  always @(negedge bus_clk) begin
    cyc = cyc + 1;
    if (!rst_sys_n) begin
      mon_tgl_i = 1'b0;
      tctr = 0;
    end else if (tgl_per != 0) begin
      tctr = tctr + 1;
      if (tctr >= tgl_per) begin
        tctr = 0;
        mon_tgl_i = ~mon_tgl_i;
        if (cyc + 2 < 100000) arr[cyc + 2] = 1'b1;
      end
    end else if (tgl_pct != 0) begin
      if ($urandom_range(0, 99) < tgl_pct) begin
        mon_tgl_i = ~mon_tgl_i;
        if (cyc + 2 < 100000) arr[cyc + 2] = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge bus_clk);
    #1;
    clr_i = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Toggles arriving at posedges p+1..p+len are counted; a back-to-back window also takes the one at p.
  function automatic logic [15:0] model_count(input int p, input int leff, input bit b2b);
    int s;
    s = b2b ? int'(arr[p]) : 0;
    for (int i = 1; i <= leff; i++) s += int'(arr[p + i]);
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic check_report();
    logic [15:0] e;
    e = exp_q.pop_front();
    check("done_pulse", done_o, 1);
    check("cnt", cnt_o, e);
    check("stuck", stuck_o, e_stuck);
    check("too_slow", too_slow_o, e_slow);
    check("too_fast", too_fast_o, e_fast);
`ifdef CLKMON_IRQ_EN
    check("irq_lag", irq_o, prev_or);
`endif
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_stuck"}, stuck_o, e_stuck);
    check({tag, "_slow"}, too_slow_o, e_slow);
    check({tag, "_fast"}, too_fast_o, e_fast);
  endtask

  // Driver: starts a window at the current step (from IDLE or from the REPORT cycle).
  task automatic do_window(input int len, input logic [15:0] mn, input logic [15:0] mx, input bit clr_rep);
    int p;
    int leff;
    bit b2b;
    logic [15:0] c;
    p    = cyc;
    leff = (len == 0) ? 1 : len;
    b2b  = (exp_q.size() > 0);
    en_i = 1'b1;
    win_len_i = 16'(len);
    exp_min_i = mn;
    exp_max_i = mx;
    for (int k = 1; k <= leff + 1; k++) begin
      step();
      if (k == 1 && exp_q.size() > 0) check_report();
      else check("done_quiet", done_o, 0);
      check("busy_win", busy_o, 1);
    end
    clr_i = clr_rep;
    c = model_count(p, leff, b2b);
`ifdef CLKMON_IRQ_EN
    prev_or = e_stuck | e_slow | e_fast;
`endif
    if (clr_rep) begin
      e_stuck = 1'b0;
      e_slow  = 1'b0;
      e_fast  = 1'b0;
    end
    if (c == 16'd0) e_stuck = 1'b1;
    if (c < mn) e_slow = 1'b1;
    if (c > mx) e_fast = 1'b1;
    exp_q.push_back(c);
    exp_cnt = c;
  endtask

  task automatic tail();
    en_i = 1'b0;
    step();
    check_report();
    check("busy_tail", busy_o, 0);
    step();
    check("done_once", done_o, 0);
`ifdef CLKMON_IRQ_EN
    check("irq_level", irq_o, e_stuck | e_slow | e_fast);
`endif
  endtask

  task automatic clear_flags();
    clr_i = 1'b1;
    step();
    e_stuck = 1'b0;
    e_slow  = 1'b0;
    e_fast  = 1'b0;
    check_flags("clr");
  endtask

  task automatic abort_window(input int len, input int at);
    en_i = 1'b1;
    win_len_i = 16'(len);
    exp_min_i = 16'd0;
    exp_max_i = 16'd0;
    for (int k = 1; k <= at; k++) begin
      step();
      check("busy_pre_abort", busy_o, 1);
    end
    en_i = 1'b0;
    step();
    check("busy_abort", busy_o, 0);
    for (int k = 0; k < 4; k++) begin
      check("done_abort", done_o, 0);
      step();
    end
    check("cnt_abort", cnt_o, exp_cnt);
    check_flags("abort");
  endtask

  initial begin
    rst_sys_n = 1'b0;
    en_i      = 1'b0;
    clr_i     = 1'b0;
    mon_tgl_i = 1'b0;
    win_len_i = 16'd0;
    exp_min_i = 16'd0;
    exp_max_i = 16'd0;
    step();
    step();
    check("rst_cnt", cnt_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check_flags("rst");
    rst_sys_n = 1'b1;
    for (int k = 0; k < 4; k++) step();

    // Nominal: toggle every 10 cycles, three back-to-back windows of 100
    tgl_per = 10;
    for (int w = 0; w < 3; w++) do_window(100, 16'd9, 16'd11, 1'b0);
    tail();

    // Stuck input
    tgl_per = 0;
    for (int k = 0; k < 5; k++) step();
    do_window(100, 16'd9, 16'd11, 1'b0);
    tail();
    clear_flags();

    // Fast input, clear coinciding with the report cycle of the second window
    tgl_per = 2;
    do_window(100, 16'd0, 16'd11, 1'b0);
    do_window(100, 16'd0, 16'd11, 1'b1);
    tail();
    clear_flags();

    // Abort mid-window
    tgl_per = 7;
    abort_window(100, 50);

    // Length 0 behaves as 1, then length 1
    do_window(0, 16'd0, 16'd5, 1'b0);
    do_window(1, 16'd0, 16'd5, 1'b0);
    tail();
    clear_flags();

    // Randomized windows, including min > max
    tgl_per = 0;
    for (int w = 0; w < 8; w++) begin
      tgl_pct = $urandom_range(0, 60);
      do_window($urandom_range(0, 150), 16'($urandom_range(0, 40)), 16'($urandom_range(0, 40)), 1'b0);
    end
    tail();
    tgl_pct = 0;
    clear_flags();

    // Saturation: preload of 1 plus 65535 edges
    tgl_per = 1;
    do_window(4, 16'd0, 16'hFFFF, 1'b0);
    do_window(65535, 16'd0, 16'hFFFF, 1'b0);
    tail();

    // Asynchronous reset mid-window
    tgl_per = 3;
    en_i = 1'b1;
    win_len_i = 16'd200;
    for (int k = 0; k < 50; k++) step();
    rst_sys_n = 1'b0;
    #1;
    check("arst_cnt", cnt_o, 0);
    check("arst_done", done_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_stuck", stuck_o, 0);
    check("arst_slow", too_slow_o, 0);
    check("arst_fast", too_fast_o, 0);
`ifdef CLKMON_IRQ_EN
    check("arst_irq", irq_o, 0);
`endif
    tgl_per = 0;
    en_i = 1'b0;
    e_stuck = 1'b0;
    e_slow  = 1'b0;
    e_fast  = 1'b0;
    exp_cnt = 16'd0;
    exp_q.delete();
    step();
    step();
    rst_sys_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("idle_after_rst", busy_o, 0);
      check("no_done_after_rst", done_o, 0);
    end

    // Restart after reset needs en_i again
    do_window(20, 16'd0, 16'd100, 1'b0);
    tail();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
